// File: rtl/key_sum_ctrl.sv
// key_sum_ctrl: debounces two active-low keys and keeps a 3-bit wrap-around press count.
// Latency: pin low at edge N -> accept at N+2+DEB_CNT -> sum/press_vld one edge later.
// Backpressure: none; every accepted press is applied the cycle after it is accepted.
// Optional auto-repeat while a key is held: define KEY_SUM_REPEAT_EN.
module key_sum_ctrl #(
  parameter int unsigned DEB_CNT    = 1_000_000,
  parameter int unsigned REPEAT_CNT = 25_000_000,
  parameter int unsigned CNT_W      = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_inc_n,
  input  logic       key_dec_n,
  output logic [2:0] sum,
  output logic       press_vld,
  output logic       key_busy
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_st_t;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CNT - 1);

  // Timers must be able to reach both terminal counts.
  if (CNT_W < 1 || (64'(DEB_CNT) >> CNT_W) != 64'd0 || (64'(REPEAT_CNT) >> CNT_W) != 64'd0) begin : g_bad_cfg
    $error("key_sum_ctrl: CNT_W too narrow for DEB_CNT/REPEAT_CNT");
  end

  // bit 0 = inc key, bit 1 = dec key
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] acc_p;
  logic [1:0] not_idle;

  // Two-flop synchronizer; released (1) is the safe reset level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
    end else begin
      sync1 <= {key_dec_n, key_inc_n};
      sync2 <= sync1;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_key
    key_st_t          st;
    logic [CNT_W-1:0] timer;
    logic             acc_q;
`ifdef KEY_SUM_REPEAT_EN
    localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CNT - 1);
    logic [CNT_W-1:0] rpt_timer;
`endif

    // Debounce FSM: a level must hold for DEB_CNT samples to change state.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st    <= IDLE;
        timer <= '0;
        acc_q <= 1'b0;
`ifdef KEY_SUM_REPEAT_EN
        rpt_timer <= '0;
`endif
      end else begin
        acc_q <= 1'b0;
        case (st)
          IDLE: begin
            if (!sync2[g]) begin
              st    <= PRESS_WAIT;
              timer <= '0;
            end
          end
          PRESS_WAIT: begin
            if (sync2[g]) begin
              st <= IDLE;
            end else if (timer == DEB_LAST) begin
              st    <= PRESSED;
              acc_q <= 1'b1;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          PRESSED: begin
            if (sync2[g]) begin
              st    <= RELEASE_WAIT;
              timer <= '0;
`ifdef KEY_SUM_REPEAT_EN
              rpt_timer <= '0;
            end else if (rpt_timer == RPT_LAST) begin
              rpt_timer <= '0;
              acc_q     <= 1'b1;
            end else begin
              rpt_timer <= rpt_timer + 1'b1;
`endif
            end
          end
          RELEASE_WAIT: begin
            if (!sync2[g]) begin
              st <= PRESSED;
            end else if (timer == DEB_LAST) begin
              st <= IDLE;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          default: st <= IDLE;
        endcase
      end
    end

    assign acc_p[g]    = acc_q;
    assign not_idle[g] = (st != IDLE);
  end

  // Apply accepted presses to the count; opposite presses in one cycle cancel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum       <= 3'd0;
      press_vld <= 1'b0;
      key_busy  <= 1'b0;
    end else begin
      press_vld <= |acc_p;
      key_busy  <= |not_idle;
      case (acc_p)
        2'b01:   sum <= sum + 3'd1;
        2'b10:   sum <= sum - 3'd1;
        default: sum <= sum;
      endcase
    end
  end

endmodule

// File: tb/tb_key_sum_ctrl.sv
// Bench for key_sum_ctrl: run-length debounce model plus directed literal checks.
module tb_key_sum_ctrl;

  localparam int DEB = 8;
  localparam int REP = 20;
`ifdef KEY_SUM_REPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_inc_n = 1'b1;
  logic       key_dec_n = 1'b1;
  logic [2:0] sum;
  logic       press_vld;
  logic       key_busy;

  key_sum_ctrl #(.DEB_CNT(DEB), .REPEAT_CNT(REP), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .key_inc_n(key_inc_n), .key_dec_n(key_dec_n),
    .sum(sum), .press_vld(press_vld), .key_busy(key_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int pv_cnt = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference model: a key is pressed once its sampled level has differed from
  // the debounced level for DEB+1 consecutive samples; samples lag the pin by 2 edges.
  bit [1:0] h1 = 2'b11, h2 = 2'b11;
  bit       m_d[2];
  int       m_run[2];
  int       m_hold[2];
  bit [1:0] m_pend = 2'b00;
  int       m_sum = 0;
  bit       m_pv = 1'b0, m_busy = 1'b0;
  bit       mk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      h1 = 2'b11; h2 = 2'b11; m_pend = 2'b00;
      m_sum = 0; m_pv = 1'b0; m_busy = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_d[i] = 1'b0; m_run[i] = 0; m_hold[i] = 0;
      end
    end else begin
      m_pv   = |m_pend;
      m_sum  = (m_sum + int'(m_pend[0]) - int'(m_pend[1]) + 8) % 8;
      m_busy = m_d[0] || m_run[0] > 0 || m_d[1] || m_run[1] > 0;
      for (int i = 0; i < 2; i++) begin
        mk = h2[i];
        m_pend[i] = 1'b0;
        if (!m_d[i]) begin
          if (!mk) begin
            m_run[i]++;
            if (m_run[i] == DEB + 1) begin
              m_d[i] = 1'b1; m_run[i] = 0; m_hold[i] = 0; m_pend[i] = 1'b1;
            end
          end else begin
            m_run[i] = 0;
          end
        end else if (mk) begin
          m_run[i]++;
          m_hold[i] = 0;
          if (m_run[i] == DEB + 1) begin
            m_d[i] = 1'b0; m_run[i] = 0;
          end
        end else if (m_run[i] > 0) begin
          m_run[i] = 0; m_hold[i] = 0;
        end else if (REPEAT_ON) begin
          m_hold[i]++;
          if (m_hold[i] == REP) begin
            m_pend[i] = 1'b1; m_hold[i] = 0;
          end
        end
      end
      h2 = h1;
      h1 = {key_dec_n, key_inc_n};
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (press_vld === 1'b1) pv_cnt++;
    if (chk_en && !rst) begin
      check("model_sum", 32'(sum), m_sum);
      check("model_press_vld", 32'(press_vld), int'(m_pv));
      check("model_key_busy", 32'(key_busy), int'(m_busy));
    end
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    step(); rst = 1'b1;
    wait_cycles(2); rst = 1'b0;
  endtask

  task automatic press(input bit inc, input bit dec, input int hold);
    step();
    if (inc) key_inc_n = 1'b0;
    if (dec) key_dec_n = 1'b0;
    wait_cycles(hold);
    key_inc_n = 1'b1; key_dec_n = 1'b1;
    wait_cycles(25);
  endtask

  // Counts negedges after the current point until press_vld is seen (bounded).
  task automatic latency_to_pulse(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (press_vld === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  int lat, pv0, s0, dur[2];

  initial begin
    wait_cycles(3);
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset_sum", 32'(sum), 0);
    check("reset_press_vld", 32'(press_vld), 0);
    check("reset_key_busy", 32'(key_busy), 0);

    // Clean press: pulse 2+DEB+1 edges after the pin falls.
    pv0 = pv_cnt;
    key_inc_n = 1'b0;
    latency_to_pulse(lat);
    check("press_latency", 32'(lat), 12);
    #1;
    wait_cycles(13);
    key_inc_n = 1'b1;
    wait_cycles(25);
    check("clean_press_sum", 32'(sum), 1);
    check("clean_press_pulses", 32'(pv_cnt - pv0), 1);

    // Bounce on press and on release: one step only.
    pv0 = pv_cnt;
    for (int c = 0; c < 20; c++) begin
      key_inc_n = 1'((c / 3) % 2);
      step();
    end
    key_inc_n = 1'b0; wait_cycles(20);
    key_inc_n = 1'b1; wait_cycles(3);
    key_inc_n = 1'b0; wait_cycles(3);
    key_inc_n = 1'b1; wait_cycles(25);
    check("bounce_sum", 32'(sum), 2);
    check("bounce_pulses", 32'(pv_cnt - pv0), 1);

    // Wrap both directions.
    do_reset();
    for (int p = 0; p < 8; p++) press(1'b1, 1'b0, 15);
    check("wrap_up_sum", 32'(sum), 0);
    press(1'b0, 1'b1, 15);
    check("wrap_down_sum", 32'(sum), 7);

    // Async reset with keys idle takes effect without a clock edge.
    step(); rst = 1'b1; #1;
    check("async_rst_sum", 32'(sum), 0);
    check("async_rst_press_vld", 32'(press_vld), 0);
    check("async_rst_key_busy", 32'(key_busy), 0);
    wait_cycles(2); rst = 1'b0;

    // Simultaneous inc/dec: pulse but no change.
    press(1'b1, 1'b0, 15);
    pv0 = pv_cnt;
    press(1'b1, 1'b1, 15);
    check("simul_sum", 32'(sum), 1);
    check("simul_pulses", 32'(pv_cnt - pv0), 1);

    // Long hold: auto-repeat only when enabled.
    do_reset();
    press(1'b1, 1'b0, 80);
    check("hold_sum", 32'(sum), REPEAT_ON ? 4 : 1);

    // Reset while debouncing with key held; full re-debounce afterwards.
    step(); key_inc_n = 1'b0;
    wait_cycles(5);
    check("pw_key_busy", 32'(key_busy), 1);
    rst = 1'b1; #1;
    check("pw_rst_sum", 32'(sum), 0);
    check("pw_rst_key_busy", 32'(key_busy), 0);
    wait_cycles(3);
    rst = 1'b0;
    latency_to_pulse(lat);
    check("rst_redebounce_latency", 32'(lat), 12);
    #1;
    key_inc_n = 1'b1;
    wait_cycles(25);
    check("rst_redebounce_sum", 32'(sum), 1);

    // Randomized key activity with occasional resets.
    dur[0] = 0; dur[1] = 0;
    for (int c = 0; c < 4000; c++) begin
      step();
      if (rst) begin
        rst = 1'b0;
      end else if ($urandom_range(0, 599) == 0) begin
        rst = 1'b1;
      end
      for (int k = 0; k < 2; k++) begin
        if (dur[k] == 0) begin
          if (k == 0) key_inc_n = 1'($urandom_range(0, 1));
          else        key_dec_n = 1'($urandom_range(0, 1));
          dur[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60))
                                               : int'($urandom_range(1, 12));
        end
        dur[k]--;
      end
    end
    rst = 1'b0; key_inc_n = 1'b1; key_dec_n = 1'b1;
    wait_cycles(30);
    s0 = m_sum;
    check("random_end_sum", 32'(sum), s0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
